hasti_xbar_mxn: RTL and testbench



---
 rtl/hasti_xbar_mxn.sv | 248 ++++++++++++++++++++++++
 tb/tb_hasti_xbar_mxn.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hasti_xbar_mxn.sv
// HASTI (AHB-Lite) M x N crossbar: base/mask decode, per-slave round-robin arbitration with
// burst/lock hold, per-master holding register for losing requests, and a 2-cycle ERROR default slave.
module hasti_xbar_mxn #(
   parameter int NUM_M = 2,
   parameter int NUM_S = 2,
   // Slave k occupies bits [k*32 +: 32]; slave 0 is the rightmost word.
   parameter logic [NUM_S*32-1:0] S_BASE = {32'h0001_0000, 32'h0000_0000},
   parameter logic [NUM_S*32-1:0] S_MASK = {32'hFFFF_0000, 32'hFFFF_0000}
) (
   input  logic                hclk,
   input  logic                hresetn,
   input  logic [NUM_M*32-1:0] m_haddr,
   input  logic [NUM_M-1:0]    m_hwrite,
   input  logic [NUM_M*3-1:0]  m_hsize,
   input  logic [NUM_M*3-1:0]  m_hburst,
   input  logic [NUM_M*4-1:0]  m_hprot,
   input  logic [NUM_M*2-1:0]  m_htrans,
   input  logic [NUM_M-1:0]    m_hmastlock,
   input  logic [NUM_M*32-1:0] m_hwdata,
   output logic [NUM_M*32-1:0] m_hrdata,
   output logic [NUM_M-1:0]    m_hready,
   output logic [NUM_M-1:0]    m_hresp,
   output logic [NUM_S-1:0]    s_hsel,
   output logic [NUM_S*32-1:0] s_haddr,
   output logic [NUM_S-1:0]    s_hwrite,
   output logic [NUM_S*3-1:0]  s_hsize,
   output logic [NUM_S*3-1:0]  s_hburst,
   output logic [NUM_S*4-1:0]  s_hprot,
   output logic [NUM_S*2-1:0]  s_htrans,
   output logic [NUM_S-1:0]    s_hmastlock,
   output logic [NUM_S*32-1:0] s_hwdata,
   input  logic [NUM_S*32-1:0] s_hrdata,
   input  logic [NUM_S-1:0]    s_hready,
   input  logic [NUM_S-1:0]    s_hresp
);

   localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PEND  = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_DERR1 = 3'd3;
   localparam logic [2:0] ST_DERR2 = 3'd4;

   localparam logic [1:0] HT_BUSY = 2'b01;
   localparam logic [1:0] HT_SEQ  = 2'b11;

   typedef struct packed {
      logic [31:0] haddr;
      logic        hwrite;
      logic [2:0]  hsize;
      logic [2:0]  hburst;
      logic [3:0]  hprot;
      logic [1:0]  htrans;
      logic        hmastlock;
   } aph_t;

   aph_t          live      [NUM_M];
   logic          live_hit  [NUM_M];
   logic [SW-1:0] live_slv  [NUM_M];
   logic          live_act  [NUM_M];
   aph_t          hold_q    [NUM_M];
   logic [2:0]    st_q      [NUM_M];
   logic [SW-1:0] slv_q     [NUM_M];
   logic [NUM_M-1:0] m_gnt;

   logic [MW-1:0]    rr_ptr    [NUM_S];
   logic [NUM_S-1:0] lock_q;
   logic [NUM_S-1:0] lock_nxt;
   logic [NUM_S-1:0] dp_vld_q;
   logic [MW-1:0]    dp_own_q  [NUM_S];
   logic [NUM_M-1:0] req       [NUM_S];
   logic [NUM_S-1:0] seq_hold;
   logic [NUM_S-1:0] lock_hold;
   logic [NUM_S-1:0] gnt_vld;
   logic [MW-1:0]    gnt_idx   [NUM_S];
   aph_t             gnt_aph   [NUM_S];

   function automatic logic [MW-1:0] rr_idx(input logic [MW-1:0] base, input int step);
      int t;
      t = int'(base) + step;
      if (t >= NUM_M) t = t - NUM_M;
      return MW'(t);
   endfunction

   // Unpack live address phases and decode; the lowest matching slave wins.
   always_comb begin
      for (int i = 0; i < NUM_M; i++) begin
         live[i].haddr     = m_haddr[i*32 +: 32];
         live[i].hwrite    = m_hwrite[i];
         live[i].hsize     = m_hsize[i*3 +: 3];
         live[i].hburst    = m_hburst[i*3 +: 3];
         live[i].hprot     = m_hprot[i*4 +: 4];
         live[i].htrans    = m_htrans[i*2 +: 2];
         live[i].hmastlock = m_hmastlock[i];
         live_hit[i] = 1'b0;
         live_slv[i] = '0;
         for (int k = NUM_S - 1; k >= 0; k--) begin
            if ((live[i].haddr & S_MASK[k*32 +: 32]) == S_BASE[k*32 +: 32]) begin
               live_hit[i] = 1'b1;
               live_slv[i] = SW'(k);
            end
         end
      end
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      m_hready = '1;
      m_hresp  = '0;
      m_hrdata = '0;
      for (int i = 0; i < NUM_M; i++) begin
         case (st_q[i])
            ST_PEND:  m_hready[i] = 1'b0;
            ST_DATA: begin
               m_hready[i]           = s_hready[slv_q[i]];
               m_hresp[i]            = s_hresp[slv_q[i]];
               m_hrdata[i*32 +: 32]  = s_hrdata[slv_q[i]*32 +: 32];
            end
            ST_DERR1: begin
               m_hready[i] = 1'b0;
               m_hresp[i]  = 1'b1;
            end
            ST_DERR2: m_hresp[i] = 1'b1;
            default:  ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_M; i++)
         live_act[i] = m_hready[i] && live[i].htrans[1];
   end

   // Per-slave arbiter: rr_ptr doubles as the current owner for the hold rule.
   always_comb begin
      for (int k = 0; k < NUM_S; k++) begin
         req[k] = '0;
         for (int i = 0; i < NUM_M; i++)
            req[k][i] = (st_q[i] == ST_PEND && slv_q[i] == SW'(k)) ||
                        (live_act[i] && live_hit[i] && live_slv[i] == SW'(k));

         if (st_q[rr_ptr[k]] == ST_PEND && slv_q[rr_ptr[k]] == SW'(k))
            seq_hold[k] = hold_q[rr_ptr[k]].htrans == HT_SEQ;
         else
            seq_hold[k] = m_hready[rr_ptr[k]] && live_hit[rr_ptr[k]] &&
                          live_slv[rr_ptr[k]] == SW'(k) &&
                          (live[rr_ptr[k]].htrans == HT_SEQ || live[rr_ptr[k]].htrans == HT_BUSY);
         // Lock is released only once the owner presents an accepted phase with hmastlock low.
         lock_hold[k] = lock_q[k] && !(m_hready[rr_ptr[k]] && !live[rr_ptr[k]].hmastlock);

         gnt_vld[k] = 1'b0;
         gnt_idx[k] = '0;
         if (s_hready[k]) begin
            if (seq_hold[k] || lock_hold[k]) begin
               gnt_vld[k] = req[k][rr_ptr[k]];
               gnt_idx[k] = rr_ptr[k];
            end else begin
               for (int j = 1; j <= NUM_M; j++) begin
                  if (!gnt_vld[k] && req[k][rr_idx(rr_ptr[k], j)]) begin
                     gnt_vld[k] = 1'b1;
                     gnt_idx[k] = rr_idx(rr_ptr[k], j);
                  end
               end
            end
         end

         if (!gnt_vld[k])
            gnt_aph[k] = '0;
         else if (st_q[gnt_idx[k]] == ST_PEND)
            gnt_aph[k] = hold_q[gnt_idx[k]];
         else
            gnt_aph[k] = live[gnt_idx[k]];
         lock_nxt[k] = gnt_vld[k] ? gnt_aph[k].hmastlock : lock_hold[k];
      end
   end

   always_comb begin
      m_gnt       = '0;
      s_hsel      = '0;
      s_haddr     = '0;
      s_hwrite    = '0;
      s_hsize     = '0;
      s_hburst    = '0;
      s_hprot     = '0;
      s_htrans    = '0;
      s_hmastlock = '0;
      s_hwdata    = '0;
      for (int k = 0; k < NUM_S; k++) begin
         if (gnt_vld[k]) m_gnt[gnt_idx[k]] = 1'b1;
         s_hsel[k]           = gnt_vld[k];
         s_haddr[k*32 +: 32] = gnt_aph[k].haddr;
         s_hwrite[k]         = gnt_aph[k].hwrite;
         s_hsize[k*3 +: 3]   = gnt_aph[k].hsize;
         s_hburst[k*3 +: 3]  = gnt_aph[k].hburst;
         s_hprot[k*4 +: 4]   = gnt_aph[k].hprot;
         s_htrans[k*2 +: 2]  = gnt_aph[k].htrans;
         s_hmastlock[k]      = gnt_aph[k].hmastlock;
         if (dp_vld_q[k]) s_hwdata[k*32 +: 32] = m_hwdata[dp_own_q[k]*32 +: 32];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         for (int i = 0; i < NUM_M; i++) begin
            st_q[i]   <= ST_IDLE;
            slv_q[i]  <= '0;
            // NOTE: holding registers are control state, not bulk storage, so they are cleared on reset.
            hold_q[i] <= '0;
         end
         for (int k = 0; k < NUM_S; k++) begin
            rr_ptr[k]   <= '0;
            dp_own_q[k] <= '0;
         end
         lock_q   <= '0;
         dp_vld_q <= '0;
      end else begin
         for (int i = 0; i < NUM_M; i++) begin
            if (m_hready[i]) begin
               if (live_act[i] && !live_hit[i]) begin
                  st_q[i] <= ST_DERR1;
               end else if (live_act[i]) begin
                  st_q[i]  <= m_gnt[i] ? ST_DATA : ST_PEND;
                  slv_q[i] <= live_slv[i];
                  if (!m_gnt[i]) hold_q[i] <= live[i];
               end else begin
                  st_q[i] <= ST_IDLE;
               end
            end else if (st_q[i] == ST_PEND && m_gnt[i]) begin
               st_q[i] <= ST_DATA;
            end else if (st_q[i] == ST_DERR1) begin
               st_q[i] <= ST_DERR2;
            end
         end
         for (int k = 0; k < NUM_S; k++) begin
            if (s_hready[k]) begin
               dp_vld_q[k] <= gnt_vld[k];
               dp_own_q[k] <= gnt_idx[k];
            end
            if (gnt_vld[k]) rr_ptr[k] <= gnt_idx[k];
         end
         lock_q <= lock_nxt;
      end
   end

endmodule

// File: tb/tb_hasti_xbar_mxn.sv
// Directed bench for hasti_xbar_mxn: two masters, a zero-wait ROM-like slave 0 and an SRAM slave 1
// with programmable wait states, checked with immediate assertions against hand-computed values.
module tb_hasti_xbar_mxn;

   localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

   logic        hclk = 1'b0;
   logic        hresetn = 1'b0;
   logic [63:0] m_haddr = '0, m_hwdata = '0, m_hrdata;
   logic [1:0]  m_hwrite = '0, m_hmastlock = '0, m_hready, m_hresp;
   logic [5:0]  m_hsize = '0, m_hburst = '0;
   logic [7:0]  m_hprot = '0;
   logic [3:0]  m_htrans = '0;
   logic [1:0]  s_hsel, s_hwrite, s_hmastlock, s_hready, s_hresp;
   logic [63:0] s_haddr, s_hwdata, s_hrdata;
   logic [5:0]  s_hsize, s_hburst;
   logic [7:0]  s_hprot;
   logic [3:0]  s_htrans;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 hclk = ~hclk;

   hasti_xbar_mxn dut (
      .hclk(hclk), .hresetn(hresetn),
      .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
      .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata),
      .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
      .s_hsel(s_hsel), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
      .s_hburst(s_hburst), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hmastlock(s_hmastlock),
      .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
   );

   // Slave models: 16-word memories, slave k stalls ws[k] cycles per transfer.
   logic [31:0] mem [2][16];
   logic [1:0]  sl_act, sl_wr;
   logic [3:0]  sl_idx  [2];
   int          sl_wait [2];
   int          ws      [2];

   always_comb begin
      s_hresp  = '0;
      s_hrdata = '0;
      for (int k = 0; k < 2; k++) begin
         s_hready[k] = (sl_wait[k] == 0);
         if (sl_act[k] && !sl_wr[k]) s_hrdata[k*32 +: 32] = mem[k][sl_idx[k]];
      end
   end

   always @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         for (int k = 0; k < 2; k++) begin
            sl_act[k]  <= 1'b0;
            sl_wr[k]   <= 1'b0;
            sl_idx[k]  <= '0;
            sl_wait[k] <= 0;
            for (int a = 0; a < 16; a++) mem[k][a] <= 32'h0;
         end
         mem[0][1] <= 32'h1234_5678;
         mem[1][1] <= 32'h1111_0001;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (s_hready[k]) begin
               if (sl_act[k] && sl_wr[k]) mem[k][sl_idx[k]] <= s_hwdata[k*32 +: 32];
               sl_act[k]  <= s_hsel[k] && s_htrans[k*2+1];
               sl_wr[k]   <= s_hwrite[k];
               sl_idx[k]  <= s_haddr[k*32+2 +: 4];
               sl_wait[k] <= (s_hsel[k] && s_htrans[k*2+1]) ? ws[k] : 0;
            end else begin
               sl_wait[k] <= sl_wait[k] - 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int i, input logic [1:0] tr, input logic [31:0] a, input logic wr,
                      input logic lk, input logic [2:0] bu);
      m_htrans[i*2 +: 2]  = tr;
      m_haddr[i*32 +: 32] = a;
      m_hwrite[i]         = wr;
      m_hmastlock[i]      = lk;
      m_hburst[i*3 +: 3]  = bu;
      m_hsize[i*3 +: 3]   = 3'd2;
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ws[0] = 0;
      ws[1] = 0;
      repeat (2) @(posedge hclk);
      #1;
      chk("rst_m_hready", 64'(m_hready), 64'h3);
      chk("rst_m_hresp", 64'(m_hresp), 64'h0);
      chk("rst_m_hrdata", m_hrdata, 64'h0);
      chk("rst_s_hsel", 64'(s_hsel), 64'h0);
      chk("rst_s_htrans", 64'(s_htrans), 64'h0);
      chk("rst_s_haddr", s_haddr, 64'h0);
      hresetn = 1'b1;

      // Uncontended ROM read
      tick(); drv(0, NONSEQ, 32'h4, 1'b0, 1'b0, 3'd0); #1;
      chk("unc_hsel0", 64'(s_hsel), 64'h1);
      chk("unc_haddr0", 64'(s_haddr[31:0]), 64'h4);
      chk("unc_hready", 64'(m_hready[0]), 64'h1);
      tick(); drv(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0); #1;
      chk("unc_hrdata", 64'(m_hrdata[31:0]), 64'h1234_5678);
      chk("unc_hready_dp", 64'(m_hready[0]), 64'h1);
      chk("unc_hresp", 64'(m_hresp[0]), 64'h0);

      // Contention: m1 wins with rr_ptr=0, m0 pends one cycle
      tick(); drv(0, NONSEQ, 32'h1_0000, 1'b0, 1'b0, 3'd0); drv(1, NONSEQ, 32'h1_0000, 1'b1, 1'b0, 3'd0); #1;
      chk("cont_hsel", 64'(s_hsel), 64'h2);
      chk("cont_m1_first", 64'(s_hwrite[1]), 64'h1);
      tick(); drv(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0); drv(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
      m_hwdata[63:32] = 32'hDEAD_BEEF; #1;
      chk("cont_m0_pend", 64'(m_hready), 64'h2);
      chk("cont_m0_gnt", 64'({s_hsel[1], s_hwrite[1]}), 64'h2);
      chk("cont_hwdata", 64'(s_hwdata[63:32]), 64'hDEAD_BEEF);
      tick(); #1;
      chk("cont_m0_ready", 64'(m_hready[0]), 64'h1);
      chk("cont_m0_rdata", 64'(m_hrdata[31:0]), 64'hDEAD_BEEF);
      chk("cont_sram", 64'(mem[1][0]), 64'hDEAD_BEEF);

      // rr_ptr back at 0: m1 wins again
      tick(); drv(0, NONSEQ, 32'h1_0004, 1'b0, 1'b0, 3'd0); drv(1, NONSEQ, 32'h1_0000, 1'b0, 1'b0, 3'd0); #1;
      chk("rr_m1_again", 64'(s_haddr[63:32]), 64'h1_0000);
      tick(); drv(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0); drv(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0); #1;
      chk("rr_m0_pend", 64'(m_hready[0]), 64'h0);
      chk("rr_m0_addr", 64'(s_haddr[63:32]), 64'h1_0004);
      chk("rr_m1_rdata", 64'(m_hrdata[63:32]), 64'hDEAD_BEEF);
      tick(); #1;
      chk("rr_m0_rdata", 64'(m_hrdata[31:0]), 64'h1111_0001);

      // Unmapped address: two-cycle ERROR, no hsel; IDLE to same address is OKAY
      tick(); drv(1, NONSEQ, 32'h8000_0000, 1'b0, 1'b0, 3'd0); #1;
      chk("ds_accept", 64'(m_hready[1]), 64'h1);
      chk("ds_no_hsel_a", 64'(s_hsel), 64'h0);
      tick(); drv(1, IDLE, 32'h8000_0000, 1'b0, 1'b0, 3'd0); #1;
      chk("ds_err1", 64'({m_hready[1], m_hresp[1]}), 64'h1);
      chk("ds_no_hsel_b", 64'(s_hsel), 64'h0);
      tick(); #1;
      chk("ds_err2", 64'({m_hready[1], m_hresp[1]}), 64'h3);
      tick(); #1;
      chk("ds_idle_okay", 64'({m_hready[1], m_hresp[1]}), 64'h2);

      // Locked read then write by m0; m1 held until m0 drops hmastlock
      tick(); drv(0, NONSEQ, 32'h1_0004, 1'b0, 1'b1, 3'd0); #1;
      chk("lk_gnt", 64'({s_hsel[1], s_hmastlock[1]}), 64'h3);
      tick(); drv(0, NONSEQ, 32'h1_0008, 1'b1, 1'b1, 3'd0); drv(1, NONSEQ, 32'h1_0000, 1'b0, 1'b0, 3'd0); #1;
      chk("lk_m0_keeps", 64'({s_hwrite[1], s_haddr[63:32]}), 64'h1_0001_0008);
      chk("lk_rd_data", 64'(m_hrdata[31:0]), 64'h1111_0001);
      tick(); drv(0, IDLE, 32'h0, 1'b0, 1'b1, 3'd0); drv(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
      m_hwdata[31:0] = 32'hCAFE_0001; #1;
      chk("lk_m1_blocked", 64'({s_hsel[1], m_hready[1]}), 64'h0);
      tick(); drv(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0); #1;
      chk("lk_release", 64'({s_hsel[1], m_hready[1], s_haddr[63:32]}), {30'h0, 2'b10, 32'h1_0000});
      tick(); #1;
      chk("lk_m1_rdata", 64'({m_hready[1], m_hrdata[63:32]}), {31'h0, 1'b1, 32'hDEAD_BEEF});
      chk("lk_sram_wr", 64'(mem[1][2]), 64'hCAFE_0001);

      // INCR4 burst from m0 is not interrupted by m1
      tick(); drv(0, NONSEQ, 32'h1_0000, 1'b0, 1'b0, 3'd3); drv(1, NONSEQ, 32'h1_0004, 1'b0, 1'b0, 3'd0); #1;
      chk("bu_start", 64'({s_hburst[5:3], s_haddr[63:32]}), {29'h0, 3'd3, 32'h1_0000});
      for (int b = 1; b < 4; b++) begin
         tick(); drv(0, SEQ, 32'h1_0000 + 32'(4*b), 1'b0, 1'b0, 3'd3); drv(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0); #1;
         chk("bu_seq_addr", 64'({s_htrans[3:2], s_haddr[63:32]}), {30'h0, SEQ, 32'h1_0000 + 32'(4*b)});
         chk("bu_m1_pend", 64'(m_hready[1]), 64'h0);
      end
      tick(); drv(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0); #1;
      chk("bu_m1_gnt", 64'({s_htrans[3:2], s_haddr[63:32]}), {30'h0, NONSEQ, 32'h1_0004});
      chk("bu_m1_still_pend", 64'(m_hready[1]), 64'h0);
      tick(); #1;
      chk("bu_m1_rdata", 64'({m_hready[1], m_hrdata[63:32]}), {31'h0, 1'b1, 32'h1111_0001});

      // Wait states on SRAM, reset pulsed mid-wait
      ws[1] = 3;
      tick(); drv(1, NONSEQ, 32'h1_000C, 1'b1, 1'b0, 3'd0); #1;
      chk("ws_gnt", 64'(s_hsel), 64'h2);
      tick(); drv(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0); m_hwdata[63:32] = 32'h55AA_55AA; #1;
      chk("ws_stall", 64'(m_hready[1]), 64'h0);
      tick(); hresetn = 1'b0; #1;
      chk("mr_m_hready", 64'(m_hready), 64'h3);
      chk("mr_m_hresp", 64'(m_hresp), 64'h0);
      chk("mr_m_hrdata", m_hrdata, 64'h0);
      chk("mr_s_hsel", 64'({s_hsel, s_htrans}), 64'h0);
      chk("mr_s_hwdata", s_hwdata, 64'h0);
      hresetn = 1'b1;
      ws[1] = 1;
      tick(); drv(1, NONSEQ, 32'h1_000C, 1'b1, 1'b0, 3'd0); #1;
      chk("post_gnt", 64'({s_hsel, m_hready[1]}), 64'h5);
      tick(); drv(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0); m_hwdata[63:32] = 32'h600D_600D; #1;
      chk("post_wait", 64'(m_hready[1]), 64'h0);
      tick(); #1;
      chk("post_done", 64'({m_hready[1], m_hresp[1]}), 64'h2);
      tick(); #1;
      chk("post_sram", 64'(mem[1][3]), 64'h600D_600D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
